// File: rtl/fetch_buffer_pkg.sv
// fetch_buffer_pkg: shared widths, default queue depth and the queue entry type
// used by the fetch buffer and its storage array.
package fetch_buffer_pkg;

    localparam int unsigned PC_W          = 16;
    localparam int unsigned INST_W        = 32;
    localparam int unsigned DEFAULT_DEPTH = 4;

    // One queued instruction together with the address it was fetched from.
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo_mem.sv
// fetch_fifo_mem: DEPTH x fetch_entry_t register array for the fetch queue.
// One synchronous write port, one asynchronous read port; contents are not reset.
// Ports:
//   clk    - clock
//   we     - write enable
//   waddr  - write index
//   wdata  - entry to write
//   raddr  - read index
//   rdata  - entry at raddr (combinational)
module fetch_fifo_mem
    import fetch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  fetch_entry_t             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output fetch_entry_t             rdata
);

    fetch_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: issues instruction-memory reads for incoming fetch addresses and
// queues the returning instructions in order for the decode stage. A credit
// check (queued + in-flight < DEPTH) guarantees every response has a free slot.
// Optional feature: define FETCH_BUF_BYPASS_EN to forward a response straight
// to dec_* when the queue is empty (one cycle less latency).
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   pc_in, pc_valid - fetch address and its valid
//   pc_stall        - fetch not accepted this cycle
//   imem_req/addr   - instruction-memory read strobe and address
//   imem_rdata      - read data, one cycle after imem_req
//   flush           - discard all queued and in-flight instructions
//   dec_valid/ready - decode handshake
//   dec_inst/dec_pc - head instruction and its address
//   occupancy       - number of queued entries
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [15:0]            pc_in,
    input  logic                   pc_valid,
    output logic                   pc_stall,
    output logic                   imem_req,
    output logic [15:0]            imem_addr,
    input  logic [31:0]            imem_rdata,
    input  logic                   flush,
    output logic                   dec_valid,
    input  logic                   dec_ready,
    output logic [31:0]            dec_inst,
    output logic [15:0]            dec_pc,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             inflight;
    logic [PC_W-1:0]  inflight_pc;

    logic         credit;
    logic         accept;
    logic         push;
    logic         pop;
    logic         bypass;
    fetch_entry_t head_entry;
    fetch_entry_t wr_entry;

    // Credit counts the pending response; a same-cycle pop does not free a slot.
    assign credit = (CNT_W'(count) + CNT_W'(inflight)) < CNT_W'(DEPTH);
    assign accept = pc_valid & ~flush & ~rst & credit;

    assign imem_req  = accept;
    assign imem_addr = pc_in;
    assign pc_stall  = pc_valid & ~accept;
    assign occupancy = count;

`ifdef FETCH_BUF_BYPASS_EN
    // Response forwarded to decode while the queue is empty; if decode takes it,
    // it never enters the queue.
    assign bypass    = (count == '0) & inflight & ~flush;
    assign dec_valid = ((count != '0) | bypass) & ~flush;
    assign dec_inst  = bypass ? imem_rdata : head_entry.inst;
    assign dec_pc    = bypass ? inflight_pc : head_entry.pc;
    assign push      = inflight & ~flush & ~(bypass & dec_ready);
`else
    assign bypass    = 1'b0;
    assign dec_valid = (count != '0) & ~flush;
    assign dec_inst  = head_entry.inst;
    assign dec_pc    = head_entry.pc;
    assign push      = inflight & ~flush;
`endif

    // Only queued entries are popped; a bypassed response never touches head.
    assign pop = dec_ready & (count != '0) & ~flush & ~bypass;

    assign wr_entry.inst = imem_rdata;
    assign wr_entry.pc   = inflight_pc;

    fetch_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (tail),
        .wdata (wr_entry),
        .raddr (head),
        .rdata (head_entry)
    );

    // Queue pointers and occupancy; flush wins over push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // One outstanding read at most per cycle; accept is already zero under flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= accept;
            if (accept) begin
                inflight_pc <= pc_in;
            end
        end
    end

endmodule
